// File: rtl/reg_map_pkg.sv
// reg_map_pkg
//   Peripheral address map shared by the bus decoder and anything that needs to
//   know where a byte address lands.
//   - Fixed register addresses (reset control, bus-error address).
//   - Target enum (indexes the per-target request/ready/rdata vectors).
//   - decode_addr(): pure address -> {kind, target} decode.
package reg_map_pkg;

  localparam logic [31:0] R_RESET_CTRL     = 32'hf800_0000;
  localparam logic [31:0] R_BUS_ERR_ADDR   = 32'hf800_0004;
  localparam logic [31:0] BASE_ILA_RAM     = 32'hf810_0000;
  localparam logic [31:0] BASE_SCRATCH_RAM = 32'hf820_0000;
  localparam logic [31:0] BASE_OVERLAY_RAM = 32'hf830_0000;
  localparam logic [31:0] BASE_PERIPH      = 32'hf800_0000;

  typedef enum logic [1:0] {TGT_MEM, TGT_ILA, TGT_SCR, TGT_OVL} tgt_e;
  localparam int NUM_TGT = 4;

  // Read data returned to the CPU when a target is aborted by the watchdog.
  localparam logic [31:0] BUS_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Where an access goes: an external target, one of the two local registers,
  // or nowhere (answered locally with zero).
  typedef enum logic [1:0] {DEC_EXT, DEC_RC, DEC_EA, DEC_UNMAP} dec_kind_e;

  typedef struct packed {
    dec_kind_e kind;
    tgt_e      sel;   // meaningful only when kind == DEC_EXT
  } dec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  // The exact-match registers sit inside the 0xf80x_xxxx window, so they are
  // tested first; the rest of that window falls through to UNMAPPED.
  function automatic dec_t decode_addr(input logic [31:0] addr);
    dec_t d;
    d.kind = DEC_EXT;
    d.sel  = TGT_MEM;
    if (addr == R_RESET_CTRL)          d.kind = DEC_RC;
    else if (addr == R_BUS_ERR_ADDR)   d.kind = DEC_EA;
    else if (addr[31:20] == 12'hf81)   d.sel  = TGT_ILA;
    else if (addr[31:20] == 12'hf82)   d.sel  = TGT_SCR;
    else if (addr[31:20] == 12'hf83)   d.sel  = TGT_OVL;
    else if (addr < BASE_PERIPH)       d.sel  = TGT_MEM;
    else                               d.kind = DEC_UNMAP;
    return d;
  endfunction

endpackage

// File: rtl/periph_bus_decoder.sv
// periph_bus_decoder
//   Routes each CPU data-bus access to MEM / ILA / SCRATCH / OVERLAY, answers the
//   reset-control and bus-error-address registers locally, answers unmapped
//   accesses with zero, and aborts any target that holds off ready too long.
//
//   clk, rst_n            clock, async active-low reset
//   cpu_valid/addr/wdata/wstrb   CPU request (wstrb==0 is a read)
//   cpu_rdata, cpu_ready  one-cycle completion pulse with read data
//   tgt_valid[NUM_TGT]    per-target request, one-hot, indexed by tgt_e
//   tgt_addr/wdata/wstrb  shared registered copy of the accepted request
//   tgt_ready, tgt_rdata  per-target completion and read data
//   rst_ctrl              reset-control register
//   bus_err               sticky timeout flag, cleared by writing R_BUS_ERR_ADDR
module periph_bus_decoder
  import reg_map_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter logic [31:0] RESET_CTRL_INIT = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_valid,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic [3:0]                  cpu_wstrb,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_ready,
  output logic [NUM_TGT-1:0]          tgt_valid,
  output logic [31:0]                 tgt_addr,
  output logic [31:0]                 tgt_wdata,
  output logic [3:0]                  tgt_wstrb,
  input  logic [NUM_TGT-1:0]          tgt_ready,
  input  logic [NUM_TGT-1:0][31:0]    tgt_rdata,
  output logic [31:0]                 rst_ctrl,
  output logic                        bus_err
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  state_e        state;
  dec_t          dec_in, dec_q;
  logic [CW-1:0] wd_cnt;
  logic [31:0]   rdata_q;
  logic [31:0]   err_addr;
  logic [31:0]   rc_next;

  assign dec_in = decode_addr(cpu_addr);

  // Byte-strobed merge of the latched write data into the reset-control register.
  always_comb begin
    rc_next = rst_ctrl;
    for (int b = 0; b < 4; b++)
      if (tgt_wstrb[b]) rc_next[8*b +: 8] = tgt_wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dec_q     <= '{kind: DEC_UNMAP, sel: TGT_MEM};
      wd_cnt    <= '0;
      rdata_q   <= '0;
      err_addr  <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      tgt_valid <= '0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      tgt_wstrb <= '0;
      rst_ctrl  <= RESET_CTRL_INIT;
      bus_err   <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          // The CPU holds cpu_valid through the cpu_ready cycle; refusing to
          // accept while cpu_ready is high stops that from re-issuing the
          // request that just completed.
          if (cpu_valid && !cpu_ready) begin
            tgt_addr  <= cpu_addr;
            tgt_wdata <= cpu_wdata;
            tgt_wstrb <= cpu_wstrb;
            dec_q     <= dec_in;
            wd_cnt    <= '0;
            rdata_q   <= '0;
            if (dec_in.kind == DEC_EXT) begin
              tgt_valid <= NUM_TGT'(1) << dec_in.sel;
              state     <= S_ISSUE;
            end else begin
              state     <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          // Ready is checked before the watchdog so a response on the final
          // allowed cycle completes normally.
          if (tgt_ready[dec_q.sel]) begin
            rdata_q   <= tgt_rdata[dec_q.sel];
            tgt_valid <= '0;
            state     <= S_RESP;
          end else if (wd_cnt == CNT_LAST) begin
            rdata_q   <= BUS_TIMEOUT_DATA;
            tgt_valid <= '0;
            bus_err   <= 1'b1;
            err_addr  <= tgt_addr;
            state     <= S_RESP;
          end else begin
            wd_cnt    <= wd_cnt + 1'b1;
          end
        end

        S_RESP: begin
          cpu_ready <= 1'b1;
          state     <= S_IDLE;
          case (dec_q.kind)
            DEC_RC: begin
              cpu_rdata <= rst_ctrl;
              if (tgt_wstrb != 4'h0) rst_ctrl <= rc_next;
            end
            DEC_EA: begin
              cpu_rdata <= err_addr;
              // Any write acknowledges the error; the logged address stays.
              if (tgt_wstrb != 4'h0) bus_err <= 1'b0;
            end
            DEC_UNMAP: cpu_rdata <= '0;
            default:   cpu_rdata <= rdata_q;
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_decoder.sv
module tb_periph_bus_decoder;
  localparam int          TO      = 16;
  localparam logic [31:0] RC_INIT = 32'h0000_0011;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_valid;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_ready;
  logic [3:0]        tgt_valid;
  logic [31:0]       tgt_addr, tgt_wdata;
  logic [3:0]        tgt_wstrb;
  logic [3:0]        tgt_ready;
  logic [3:0][31:0]  tgt_rdata;
  logic [31:0]       rst_ctrl;
  logic              bus_err;

  periph_bus_decoder #(.TIMEOUT_CYCLES(TO), .RESET_CTRL_INIT(RC_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .tgt_valid(tgt_valid), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb),
    .tgt_ready(tgt_ready), .tgt_rdata(tgt_rdata),
    .rst_ctrl(rst_ctrl), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state of the local registers.
  logic [31:0] m_rc, m_ea;
  logic        m_err;

  // Target responders: wait_cfg[i] idle cycles of tgt_valid before one ready
  // pulse; negative means never answer.
  int          wait_cfg [4];
  logic [31:0] rsp_data [4];
  int          vcnt     [4];
  bit          stray_en = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        vcnt[i] = 0; tgt_ready[i] = 1'b0; tgt_rdata[i] = '0;
      end else if (tgt_valid[i]) begin
        tgt_ready[i] = (wait_cfg[i] >= 0) && (vcnt[i] == wait_cfg[i]);
        tgt_rdata[i] = tgt_ready[i] ? rsp_data[i] : $urandom;
        vcnt[i]++;
      end else begin
        vcnt[i] = 0;
        tgt_ready[i] = stray_en && ($urandom_range(3) == 0);
        tgt_rdata[i] = $urandom;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU access, checked against the address map and target behaviour.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int waits, input logic [31:0] trd, input bit drop);
    int kind, idx, exp_lat, exp_vc, lat, vc;
    logic [31:0] exp_rd, rd, ta, twd;
    logic [3:0]  exp_tv, tv_or, tws;
    bit first;
    idx = 0; exp_vc = 0; exp_tv = '0; exp_rd = '0;
    // kind: 0 external, 1 reset ctrl, 2 err addr, 3 unmapped
    if (a == 32'hf800_0000)                               kind = 1;
    else if (a == 32'hf800_0004)                          kind = 2;
    else if (a >= 32'hf810_0000 && a < 32'hf840_0000) begin
      kind = 0; idx = int'((a - 32'hf800_0000) >> 20);
    end
    else if (a < 32'hf800_0000)                           kind = 0;
    else                                                  kind = 3;
    case (kind)
      0: begin
        wait_cfg[idx] = waits; rsp_data[idx] = trd; exp_tv = 4'b0001 << idx;
        if (waits >= 0) begin exp_lat = 3 + waits; exp_vc = waits + 1; exp_rd = trd; end
        else begin exp_lat = TO + 2; exp_vc = TO; exp_rd = 32'hDEAD_BEEF; end
      end
      1:       begin exp_lat = 2; exp_rd = m_rc; end
      2:       begin exp_lat = 2; exp_rd = m_ea; end
      default: begin exp_lat = 2; exp_rd = '0; end
    endcase

    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    lat = 0; vc = 0; tv_or = '0; first = 1'b1; ta = '0; twd = '0; tws = '0;
    while (!cpu_ready && lat < 4*TO + 20) begin
      @(negedge clk);
      lat++;
      if (drop) cpu_valid = 1'b0;
      if (tgt_valid != 4'h0) begin
        vc++;
        if (first) begin ta = tgt_addr; twd = tgt_wdata; tws = tgt_wstrb; first = 1'b0; end
      end
      tv_or |= tgt_valid;
    end
    rd = cpu_rdata;
    cpu_valid = 1'b0;

    if (kind == 0 && waits < 0) begin m_err = 1'b1; m_ea = a; end
    if (kind == 1) for (int b = 0; b < 4; b++) if (s[b]) m_rc[8*b +: 8] = d[8*b +: 8];
    if (kind == 2 && s != 4'h0) m_err = 1'b0;

    chk("latency", lat, exp_lat);
    if (s == 4'h0) chk("rdata", rd, exp_rd);
    chk("tgt_valid_set", tv_or, exp_tv);
    if (kind == 0) begin
      chk("valid_cycles", vc, exp_vc);
      chk("tgt_addr", ta, a);
      chk("tgt_wdata", twd, d);
      chk("tgt_wstrb", tws, s);
    end
    chk("rst_ctrl", rst_ctrl, m_rc);
    chk("bus_err", bus_err, m_err);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int w, n;
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    m_rc = RC_INIT; m_ea = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_tgt_valid", tgt_valid, 4'h0);
    chk("rst_tgt_addr", tgt_addr, 32'h0);
    chk("rst_rst_ctrl", rst_ctrl, RC_INIT);
    chk("rst_bus_err", bus_err, 1'b0);
    rst_n = 1'b1;

    // Reset-control byte-strobed writes.
    access(32'hf800_0000, 32'h0000_00A5, 4'hF, 0, 0, 0);
    chk("t1_rc_a5", rst_ctrl, 32'h0000_00A5);
    access(32'hf800_0000, 32'h0000_FF00, 4'h2, 0, 0, 0);
    chk("t1_rc_ffa5", rst_ctrl, 32'h0000_FFA5);
    access(32'hf800_0000, 32'h0, 4'h0, 0, 0, 0);

    // Scratch read with three wait cycles; unmapped read.
    access(32'hf820_0010, 32'h0, 4'h0, 3, 32'h1234_5678, 0);
    access(32'hf900_0000, 32'h0, 4'h0, 0, 0, 0);

    // Overlay timeout, error address readback, clear by write.
    access(32'hf830_0000, 32'h0, 4'h0, -1, 0, 0);
    chk("t4_bus_err_set", bus_err, 1'b1);
    access(32'hf800_0004, 32'h0, 4'h0, 0, 0, 0);
    access(32'hf800_0004, 32'h1, 4'h1, 0, 0, 0);
    chk("t4_bus_err_clr", bus_err, 1'b0);
    access(32'hf800_0004, 32'h0, 4'h0, 0, 0, 0);

    // Ready on the very last allowed cycle wins over the watchdog.
    access(32'hf810_0000, 32'h0, 4'h0, TO - 1, 32'hCAFE_0001, 0);

    // Back-to-back zero-wait MEM reads with stray ready pulses elsewhere.
    stray_en = 1'b1;
    for (int i = 0; i < 4; i++) access($urandom_range(32'hf7ff_ffff), 32'h0, 4'h0, 0, $urandom, 0);

    // CPU drops valid early: transaction still completes.
    access(32'hf800_0000, 32'h0, 4'h0, 0, 0, 1);
    access(32'hf820_0100, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      s = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      d = $urandom;
      w = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(4));
      case ($urandom_range(5))
        0:       a = 32'hf800_0000;
        1:       begin a = 32'hf800_0004; if ($urandom_range(2) != 0) s = 4'h0; end
        2:       begin a = $urandom_range(32'hf7ff_ffff); if (w < 0) w = 1; end
        3:       a = 32'hf800_0000 + (32'($urandom_range(3, 1)) << 20) + 32'($urandom_range(32'h000f_ffff));
        4:       a = 32'hf800_0008 + $urandom_range(32'h000f_fff7);
        default: a = 32'hf840_0000 + $urandom_range(32'h07bf_ffff);
      endcase
      access(a, d, s, w, $urandom, 0);
    end
    stray_en = 1'b0;

    // Make sure there is something non-default to reset.
    access(32'hf830_0020, 32'h0, 4'h0, -1, 0, 0);
    access(32'hf800_0000, 32'h0000_7700, 4'h2, 0, 0, 0);

    // Reset in the middle of an ISSUE.
    wait_cfg[2] = -1;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'hf820_0040; cpu_wdata = '0; cpu_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("t6_valid_before", tgt_valid, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", tgt_valid, 4'h0);
    chk("t6_rst_ctrl", rst_ctrl, RC_INIT);
    chk("t6_bus_err", bus_err, 1'b0);
    chk("t6_cpu_ready", cpu_ready, 1'b0);
    cpu_valid = 1'b0;
    m_rc = RC_INIT; m_ea = '0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (cpu_ready) n++; end
    chk("t6_no_ready", n, 0);
    access(32'hf800_0004, 32'h0, 4'h0, 0, 0, 0);
    access(32'hf800_0000, 32'h0, 4'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
